// File: rtl/uart_image_loader_if.sv
// Handshake and status bundle between the image loader, the UART byte receiver,
// the image RAM write port and the processor control unit.
interface uart_image_loader_if #(
  parameter int ADDR_W = 16
);
  logic              start;
  logic              rx_rdy;
  logic [7:0]        rx_data;
  logic              rx_rdy_clr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] byte_count;

  modport master (
    input  start, rx_rdy, rx_data,
    output rx_rdy_clr, mem_we, mem_addr, mem_wdata, busy, done, err, byte_count
  );

  modport slave (
    output start, rx_rdy, rx_data,
    input  rx_rdy_clr, mem_we, mem_addr, mem_wdata, busy, done, err, byte_count
  );
endinterface

// File: rtl/uart_image_loader.sv
// Loads one length-prefixed, XOR-checksummed frame from the UART receiver into
// image RAM as sequential byte writes starting at BASE_ADDR.
module uart_image_loader #(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input logic                 clk_,
  input logic                 rst,
  uart_image_loader_if.master bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CHECK  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic              clr_pend_q, clr_pend_d;
  logic              rx_rdy_clr_q, rx_rdy_clr_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] byte_count_q, byte_count_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [7:0]        chk_q, chk_d;

  logic              consume;
  logic [15:0]       len_full;
  logic [ADDR_W-1:0] len_new;
  logic [ADDR_W-1:0] count_inc;

  // The receiver only drops rdy a cycle after our acknowledge, so clr_pend masks
  // that stale rdy and limits consumption to one byte every two cycles.
  assign consume   = bus.rx_rdy && !clr_pend_q && (state_q != S_IDLE);
  assign len_full  = {bus.rx_data, len_q[7:0]};
  assign len_new   = ADDR_W'(len_full);
  assign count_inc = byte_count_q + ADDR_W'(1);

  always_comb begin
    state_d      = state_q;
    clr_pend_d   = consume;
    rx_rdy_clr_d = consume;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    done_d       = 1'b0;
    err_d        = err_q;
    byte_count_d = byte_count_q;
    len_d        = len_q;
    chk_d        = chk_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          err_d        = 1'b0;
          byte_count_d = '0;
          chk_d        = 8'h00;
          state_d      = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (consume) begin
          len_d   = ADDR_W'(bus.rx_data);
          state_d = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (consume) begin
          len_d = len_new;
          if (len_new == '0) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      // Address is formed from the pre-increment count so payload byte 0 lands at BASE_ADDR.
      S_DATA: begin
        if (consume) begin
          mem_we_d     = 1'b1;
          mem_addr_d   = BASE_ADDR + byte_count_q;
          mem_wdata_d  = bus.rx_data;
          byte_count_d = count_inc;
          chk_d        = chk_q ^ bus.rx_data;
          if (count_inc == len_q) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (consume) begin
          err_d   = err_q | (bus.rx_data != chk_q);
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_ or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      clr_pend_q   <= 1'b0;
      rx_rdy_clr_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= BASE_ADDR;
      mem_wdata_q  <= 8'h00;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      byte_count_q <= '0;
      len_q        <= '0;
      chk_q        <= 8'h00;
    end else begin
      state_q      <= state_d;
      clr_pend_q   <= clr_pend_d;
      rx_rdy_clr_q <= rx_rdy_clr_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      done_q       <= done_d;
      err_q        <= err_d;
      byte_count_q <= byte_count_d;
      len_q        <= len_d;
      chk_q        <= chk_d;
    end
  end

  assign bus.rx_rdy_clr = rx_rdy_clr_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.byte_count = byte_count_q;
  assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_image_loader.sv
// Drives two loaders (base 0 and base FFFE) with identical frames and checks them
// against a frame-level model of expected writes, acknowledges and status.
module tb_uart_image_loader;

  logic clk_ = 1'b0;
  logic rst;
  logic startDrv;
  logic rxRdyDrv;
  logic [7:0] rxDataDrv;

  int vectors = 0;
  int mismatches = 0;

  logic [23:0] expW[2][$];
  int clrCnt[2];
  int doneCnt[2];
  logic prevClr[2];
  logic [7:0] frameQ[$];

  uart_image_loader_if #(.ADDR_W(16)) bus0 ();
  uart_image_loader_if #(.ADDR_W(16)) bus1 ();

  assign bus0.start   = startDrv;
  assign bus0.rx_rdy  = rxRdyDrv;
  assign bus0.rx_data = rxDataDrv;
  assign bus1.start   = startDrv;
  assign bus1.rx_rdy  = rxRdyDrv;
  assign bus1.rx_data = rxDataDrv;

  uart_image_loader #(.ADDR_W(16), .BASE_ADDR(16'h0000)) dut0 (
    .clk_ (clk_),
    .rst  (rst),
    .bus  (bus0)
  );

  uart_image_loader #(.ADDR_W(16), .BASE_ADDR(16'hFFFE)) dut1 (
    .clk_ (clk_),
    .rst  (rst),
    .bus  (bus1)
  );

  always #5 clk_ = ~clk_;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      mismatches++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkDut(input int k, input logic we, input logic [15:0] addr,
                          input logic [7:0] wd, input logic clr, input logic done,
                          input logic busy);
    logic [23:0] e;
    if (we) begin
      if (expW[k].size() == 0) begin
        checkOutput($sformatf("spuriousWrite%0d", k), {addr, wd}, 32'h0);
      end else begin
        e = expW[k].pop_front();
        checkOutput($sformatf("writeAddrData%0d", k), {8'h00, addr, wd}, {8'h00, e});
      end
      checkOutput($sformatf("writeWithAck%0d", k), {31'b0, clr}, 32'd1);
    end
    if (clr) begin
      clrCnt[k]++;
      checkOutput($sformatf("singleCycleAck%0d", k), {31'b0, prevClr[k]}, 32'd0);
    end
    prevClr[k] = clr;
    if (done) begin
      doneCnt[k]++;
      checkOutput($sformatf("doneWithLastAck%0d", k), {31'b0, clr}, 32'd1);
      checkOutput($sformatf("doneNotBusy%0d", k), {31'b0, busy}, 32'd0);
    end
  endtask

  always @(negedge clk_) begin
    if (rst) begin
      prevClr[0] = 1'b0;
      prevClr[1] = 1'b0;
    end else begin
      checkDut(0, bus0.mem_we, bus0.mem_addr, bus0.mem_wdata, bus0.rx_rdy_clr, bus0.done, bus0.busy);
      checkDut(1, bus1.mem_we, bus1.mem_addr, bus1.mem_wdata, bus1.rx_rdy_clr, bus1.done, bus1.busy);
    end
  end

  task automatic checkReset(input string tag);
    checkOutput({tag, "Clr"},   {31'b0, bus0.rx_rdy_clr}, 32'd0);
    checkOutput({tag, "We"},    {31'b0, bus0.mem_we}, 32'd0);
    checkOutput({tag, "Done"},  {31'b0, bus0.done}, 32'd0);
    checkOutput({tag, "Err"},   {31'b0, bus0.err}, 32'd0);
    checkOutput({tag, "Busy"},  {31'b0, bus0.busy}, 32'd0);
    checkOutput({tag, "Addr0"}, {16'b0, bus0.mem_addr}, 32'h0000);
    checkOutput({tag, "Wdata"}, {24'b0, bus0.mem_wdata}, 32'h00);
    checkOutput({tag, "Count"}, {16'b0, bus0.byte_count}, 32'd0);
    checkOutput({tag, "Addr1"}, {16'b0, bus1.mem_addr}, 32'hFFFE);
    checkOutput({tag, "Busy1"}, {31'b0, bus1.busy}, 32'd0);
  endtask

  task automatic nextCycle;
    @(posedge clk_);
    #1;
  endtask

  task automatic pulseStart;
    startDrv = 1'b1;
    nextCycle();
    startDrv = 1'b0;
  endtask

  // Receiver model: rdy stays up until the acknowledge is seen, then drops on the next edge.
  task automatic sendByte(input logic [7:0] b, input int gap);
    bit got;
    rxRdyDrv = 1'b0;
    repeat (gap) nextCycle();
    rxRdyDrv  = 1'b1;
    rxDataDrv = b;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk_);
      if (bus0.rx_rdy_clr) got = 1'b1;
    end
    checkOutput("ackSeen", {31'b0, got}, 32'd1);
    nextCycle();
    rxRdyDrv = 1'b0;
  endtask

  // Predicts the frame outcome from the byte list alone, then plays it into both loaders.
  task automatic applyStimulus(input int gap);
    int lenV;
    int nBytes;
    logic [7:0] x;
    logic [7:0] d;
    bit expErr;
    int clrBase0, clrBase1, doneBase0, doneBase1;

    nBytes = frameQ.size();
    lenV   = int'(frameQ[0]) + 256 * int'(frameQ[1]);
    x      = 8'h00;
    for (int i = 0; i < lenV; i++) begin
      d = frameQ[2 + i];
      x = x ^ d;
      expW[0].push_back({16'(i), d});
      expW[1].push_back({16'(32'hFFFE + i), d});
    end
    expErr = (lenV == 0) ? 1'b1 : (x != frameQ[2 + lenV]);

    clrBase0  = clrCnt[0];
    clrBase1  = clrCnt[1];
    doneBase0 = doneCnt[0];
    doneBase1 = doneCnt[1];

    pulseStart();
    for (int i = 0; i < nBytes; i++) sendByte(frameQ[i], gap);
    repeat (2) nextCycle();

    checkOutput("writesLeft0", expW[0].size(), 32'd0);
    checkOutput("writesLeft1", expW[1].size(), 32'd0);
    checkOutput("ackCount0", clrCnt[0] - clrBase0, nBytes);
    checkOutput("ackCount1", clrCnt[1] - clrBase1, nBytes);
    checkOutput("doneCount0", doneCnt[0] - doneBase0, 32'd1);
    checkOutput("doneCount1", doneCnt[1] - doneBase1, 32'd1);
    checkOutput("frameErr0", {31'b0, bus0.err}, {31'b0, expErr});
    checkOutput("frameErr1", {31'b0, bus1.err}, {31'b0, expErr});
    checkOutput("frameCount0", {16'b0, bus0.byte_count}, lenV);
    checkOutput("frameCount1", {16'b0, bus1.byte_count}, lenV);
    checkOutput("idleAfter0", {31'b0, bus0.busy}, 32'd0);
    expW[0].delete();
    expW[1].delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    clrCnt  = '{0, 0};
    doneCnt = '{0, 0};
    prevClr = '{1'b0, 1'b0};
    rst = 1'b1;
    startDrv = 1'b0;
    rxRdyDrv = 1'b0;
    rxDataDrv = 8'h00;
    repeat (3) nextCycle();
    checkReset("reset");
    @(negedge clk_);
    rst = 1'b0;
    nextCycle();

    frameQ = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
    applyStimulus(2);
    checkOutput("singleLastAddr0", {16'b0, bus0.mem_addr}, 32'h0002);
    checkOutput("wrapLastAddr1", {16'b0, bus1.mem_addr}, 32'h0000);
    checkOutput("singleCount", {16'b0, bus0.byte_count}, 32'd3);
    checkOutput("singleErr", {31'b0, bus0.err}, 32'd0);

    frameQ = '{8'h02, 8'h00, 8'hAA, 8'h55, 8'h00};
    applyStimulus(1);
    checkOutput("badChkErr", {31'b0, bus0.err}, 32'd1);
    checkOutput("badChkCount", {16'b0, bus0.byte_count}, 32'd2);

    frameQ = '{8'h01, 8'h00, 8'h7E, 8'h7E};
    applyStimulus(0);
    checkOutput("errClearedByStart", {31'b0, bus0.err}, 32'd0);

    frameQ = '{8'h00, 8'h00};
    applyStimulus(1);
    checkOutput("zeroLenErr", {31'b0, bus0.err}, 32'd1);
    checkOutput("zeroLenCount", {16'b0, bus0.byte_count}, 32'd0);

    base = clrCnt[0];
    rxRdyDrv  = 1'b1;
    rxDataDrv = 8'h55;
    repeat (6) nextCycle();
    rxRdyDrv = 1'b0;
    checkOutput("idleNoAck", clrCnt[0] - base, 32'd0);
    checkOutput("idleNoBusy", {31'b0, bus0.busy}, 32'd0);

    frameQ = '{8'h04, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    applyStimulus(0);
    checkOutput("stressCount", {16'b0, bus0.byte_count}, 32'd4);
    checkOutput("stressLastData", {24'b0, bus0.mem_wdata}, 32'h04);

    expW[0].push_back({16'h0000, 8'hA1});
    expW[0].push_back({16'h0001, 8'hB2});
    expW[1].push_back({16'hFFFE, 8'hA1});
    expW[1].push_back({16'hFFFF, 8'hB2});
    pulseStart();
    sendByte(8'h04, 1);
    sendByte(8'h00, 1);
    sendByte(8'hA1, 1);
    sendByte(8'hB2, 1);
    checkOutput("preResetBusy", {31'b0, bus0.busy}, 32'd1);
    checkOutput("preResetCount", {16'b0, bus0.byte_count}, 32'd2);
    checkOutput("preResetWrites", expW[0].size(), 32'd0);
    rxRdyDrv  = 1'b1;
    rxDataDrv = 8'hC7;
    #2;
    rst = 1'b1;
    #1;
    checkReset("midReset");
    repeat (2) nextCycle();
    rxRdyDrv = 1'b0;
    @(negedge clk_);
    rst = 1'b0;
    expW[0].delete();
    expW[1].delete();
    repeat (3) nextCycle();
    checkOutput("postResetIdle", {31'b0, bus0.busy}, 32'd0);

    frameQ = '{8'h02, 8'h00, 8'hC3, 8'h3C, 8'hFF};
    applyStimulus(1);
    checkOutput("reloadLastAddr0", {16'b0, bus0.mem_addr}, 32'h0001);
    checkOutput("reloadLastAddr1", {16'b0, bus1.mem_addr}, 32'hFFFF);
    checkOutput("reloadErr", {31'b0, bus0.err}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, mismatches);
    $finish;
  end

endmodule
